// File: rtl/sec_decoder_locked_pipe_if.sv
// Streaming bus for sec_decoder_locked_pipe: input word handshake with
// received data/check bits, and output handshake with corrected data,
// effective syndrome and error classification flags.
interface sec_decoder_locked_pipe_if #(
    parameter int DATA_W = 32,
    parameter int CHK_W  = 6
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W-1:0]  in_chk;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CHK_W-1:0]  out_syn;
    logic              out_corr;
    logic              out_uncorr;

    modport master (
        output in_valid, in_data, in_chk, out_ready,
        input  in_ready, out_valid, out_data, out_syn, out_corr, out_uncorr
    );

    modport slave (
        input  in_valid, in_data, in_chk, out_ready,
        output in_ready, out_valid, out_data, out_syn, out_corr, out_uncorr
    );
endinterface

// File: rtl/sec_decoder_locked_pipe.sv
// Key-locked SEC Hamming decoder, 2-stage valid/ready pipeline.
// A serially loaded key is XOR-compared against KEY_GOLD; any difference
// scrambles the syndrome and the output data.
// Optional feature macro: SEC_ERR_CNT_EN enables the saturating
// corrected/uncorrectable word counters (tied to zero otherwise).
module sec_decoder_locked_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                CHK_W    = 6,
    parameter logic [DATA_W-1:0] KEY_GOLD = 32'hA5C3_0F96,
    parameter int                CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_sin,
    input  logic                   key_shift,
    input  logic                   key_lock,
    output logic                   key_locked,
    sec_decoder_locked_pipe_if.slave bus,
    input  logic                   clr_cnt,
    output logic [CNT_W-1:0]       corr_cnt,
    output logic [CNT_W-1:0]       uncorr_cnt
);

    // Column codes: ascending CHK_W-bit values >= 3 that are not powers of two.
    function automatic logic [DATA_W*CHK_W-1:0] buildTable();
        logic [DATA_W*CHK_W-1:0] t;
        int n;
        t = '0;
        n = 32'sd0;
        for (int v = 32'sd3; v < (32'sd1 << CHK_W); v++) begin
            if (((v & (v - 32'sd1)) != 32'sd0) && (n < DATA_W)) begin
                t[n*CHK_W +: CHK_W] = v[CHK_W-1:0];
                n = n + 32'sd1;
            end
        end
        return t;
    endfunction

    localparam logic [DATA_W*CHK_W-1:0] H_TABLE = buildTable();

    // Check bits of a data word: XOR of the column codes of all set bits.
    function automatic logic [CHK_W-1:0] calcChk(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c ^ ({CHK_W{d[i]}} & H_TABLE[i*CHK_W +: CHK_W]);
        end
        return c;
    endfunction

    logic [DATA_W-1:0] keyReg;
    logic              keyLockedR;
    logic [DATA_W-1:0] mask;
    logic              en;

    logic              s1Valid;
    logic [DATA_W-1:0] s1Data;
    logic [CHK_W-1:0]  s1Syn;
    logic [DATA_W-1:0] s1Mask;

    logic [DATA_W-1:0] flip;
    logic              isCorr;
    logic              isUncorr;

    logic              outValidR;
    logic [DATA_W-1:0] outDataR;
    logic [CHK_W-1:0]  outSynR;
    logic              outCorrR;
    logic              outUncorrR;

    assign mask          = keyReg ^ KEY_GOLD;
    assign en            = !outValidR || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = outValidR;
    assign bus.out_data  = outDataR;
    assign bus.out_syn   = outSynR;
    assign bus.out_corr  = outCorrR;
    assign bus.out_uncorr = outUncorrR;
    assign key_locked    = keyLockedR;

    // Serial key register; lock uses the pre-edge state so a same-cycle shift still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keyReg     <= '0;
            keyLockedR <= 1'b0;
        end else begin
            if (key_shift && !keyLockedR) begin
                keyReg <= {keyReg[DATA_W-2:0], key_sin};
            end
            if (key_lock) begin
                keyLockedR <= 1'b1;
            end
        end
    end

    // Stage 1: capture the word with its key-adjusted syndrome and the mask in force.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid <= 1'b0;
            s1Data  <= '0;
            s1Syn   <= '0;
            s1Mask  <= '0;
        end else if (en) begin
            s1Valid <= bus.in_valid;
            s1Data  <= bus.in_data;
            s1Syn   <= calcChk(bus.in_data) ^ bus.in_chk ^ mask[CHK_W-1:0];
            s1Mask  <= mask;
        end
    end

    // Syndrome decode: locate a data-bit error or classify check-bit / uncorrectable.
    always_comb begin
        flip     = '0;
        isCorr   = 1'b0;
        isUncorr = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            flip[i] = (s1Syn == H_TABLE[i*CHK_W +: CHK_W]);
        end
        if (s1Syn == '0) begin
            isCorr   = 1'b0;
            isUncorr = 1'b0;
        end else if (|flip) begin
            isCorr = 1'b1;
        end else if ((s1Syn & (s1Syn - {{(CHK_W-1){1'b0}}, 1'b1})) == '0) begin
            isCorr = 1'b1;
        end else begin
            isUncorr = 1'b1;
        end
    end

    // Stage 2: registered outputs, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValidR  <= 1'b0;
            outDataR   <= '0;
            outSynR    <= '0;
            outCorrR   <= 1'b0;
            outUncorrR <= 1'b0;
        end else if (en) begin
            outValidR  <= s1Valid;
            outDataR   <= s1Data ^ flip ^ s1Mask;
            outSynR    <= s1Syn;
            outCorrR   <= s1Valid && isCorr;
            outUncorrR <= s1Valid && isUncorr;
        end
    end

`ifdef SEC_ERR_CNT_EN
    logic [CNT_W-1:0] corrCntR;
    logic [CNT_W-1:0] uncorrCntR;
    logic             fire;

    assign fire       = outValidR && bus.out_ready;
    assign corr_cnt   = corrCntR;
    assign uncorr_cnt = uncorrCntR;

    // Saturating error counters; clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corrCntR   <= '0;
            uncorrCntR <= '0;
        end else if (clr_cnt) begin
            corrCntR   <= '0;
            uncorrCntR <= '0;
        end else if (fire) begin
            if (outCorrR && (corrCntR != {CNT_W{1'b1}})) begin
                corrCntR <= corrCntR + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (outUncorrR && (uncorrCntR != {CNT_W{1'b1}})) begin
                uncorrCntR <= uncorrCntR + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`else
    logic unusedClr;

    assign unusedClr  = clr_cnt;
    assign corr_cnt   = '0;
    assign uncorr_cnt = '0;
`endif

endmodule
